mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the fetch port (I, read-only) and the load/store port (D, read/write) of the pipelined RV32 core.
- Sits between the core's IF/MEM stages and the memory macro.
- Sequences each access: accept, issue, wait, respond.
- D has priority; an aging counter guarantees fetch forward progress.

Parameters:
- MEM_LAT, 2: cycles from mem_en to valid mem_rdata; legal range 1..15.
- STARVE_MAX, 4: consecutive D grants allowed while i_req is pending before I is forced; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held until i_ready
- i_addr  in  32  fetch byte address
- i_ready  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid pulse
- i_rdata  out  32  fetch data
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_wstrb  in  4  store byte strobes
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid, or store-complete pulse
- d_rdata  out  32  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_wstrb  out  4  memory byte strobes
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset = 0, asynchronous):
  - FSM goes to IDLE.
  - Starvation counter, latency counter and owner register clear.
  - Every output drives 0.
  - Any in-flight transaction is dropped with no rvalid; requesters re-issue after reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE (arbitration):
  - Requests are sampled combinationally.
  - D wins if d_req = 1, unless i_req = 1 and starve_cnt == STARVE_MAX; in that case I wins.
  - The winner's x_ready is high for exactly this cycle (combinational, IDLE only).
  - Owner, address, we, wstrb and wdata are registered; the next state is ISSUE.
  - Fetch requests carry mem_we = 0 and mem_wstrb = 0.
- ISSUE:
  - mem_en = 1 for exactly one cycle, with the mem_* fields taken from the registers.
  - mem_* outputs are 0 in every cycle outside ISSUE.
  - Next state is WAIT if MEM_LAT > 1, else RESP.
- WAIT: counts MEM_LAT-1 cycles, then goes to RESP.
- RESP:
  - The owner's x_rvalid = 1 for one cycle; x_rdata = mem_rdata in that cycle.
  - On a D store, d_rvalid still pulses as the completion ack; d_rdata is don't-care.
  - Next state is IDLE.
  - x_rdata is 0 in every cycle without x_rvalid.
- Timing:
  - Acceptance in cycle A gives mem_en at A+1 and rvalid at A+1+MEM_LAT.
  - The next acceptance is no earlier than A+2+MEM_LAT.
  - Requests are never accepted outside IDLE; x_ready stays 0 while busy.
- Starvation counter (saturating, 4 bits), updated at each acceptance:
  - D granted while i_req = 1: increment, saturating at STARVE_MAX.
  - I granted: clear.
  - In any cycle with i_req = 0: clear.
- Address and data pass through unmodified; no alignment checking.
- Simultaneous i_req and d_req in IDLE: exactly one ready is asserted, never both.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds output ports i_stall_cnt (out, 32) and d_stall_cnt (out, 32).
  - Each counts cycles with x_req = 1 and x_ready = 0.
  - Counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- MEM_LAT=2; i_req with i_addr=0x40 at cycle 0, memory returns 0x00500093 -> i_ready at 0; mem_en, mem_addr=0x40, mem_we=0 at 1; i_rvalid with i_rdata=0x00500093 at 3; busy low at 4.
- D store with d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF -> mem_we=1, mem_wstrb=0xF, mem_wdata=0xDEADBEEF at 1; d_rvalid at 3; i_rvalid stays 0 throughout.
- i_req and d_req both high at cycle 0 -> d_ready at 0, i_ready at 4; rvalid order D then I.
- STARVE_MAX=4; d_req held high continuously with i_req held high -> four D grants, fifth grant to I, then D is granted again.
- reset pulsed low during WAIT -> all outputs 0 immediately; no rvalid afterwards; after release a fresh i_req is accepted in its first cycle.
- ARB_PERF_CNT_EN defined; scenario 3 -> i_stall_cnt=4 and d_stall_cnt=0 after completion.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between fetch (I) and load/store (D).
// Optional stall counters: define ARB_PERF_CNT_EN to add i_stall_cnt / d_stall_cnt.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] i_stall_cnt,
  output logic [31:0] d_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);

  state_t      state;
  logic        owner_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [3:0]  wstrb_q;
  logic [3:0]  starve_cnt;
  logic [3:0]  lat_cnt;
  logic        mem_en_q;
  logic        i_rvalid_q;
  logic        d_rvalid_q;
  logic        grant_i;
  logic        grant_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE && reset) begin
      grant_i = i_req && (!d_req || starve_cnt == STARVE_LIM);
      grant_d = d_req && !grant_i;
    end
  end

  assign i_ready = grant_i;
  assign d_ready = grant_d;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      wstrb_q    <= '0;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      mem_en_q   <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      mem_en_q   <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;

      if (!i_req || grant_i)
        starve_cnt <= '0;
      else if (grant_d && starve_cnt < STARVE_LIM)
        starve_cnt <= starve_cnt + 4'd1;

      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            owner_d  <= grant_d;
            addr_q   <= grant_d ? d_addr : i_addr;
            we_q     <= grant_d && d_we;
            wstrb_q  <= grant_d ? d_wstrb : 4'h0;
            wdata_q  <= grant_d ? d_wdata : 32'h0;
            mem_en_q <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (MEM_LAT > 1) begin
            lat_cnt <= 4'd1;
            state   <= WAIT;
          end else begin
            i_rvalid_q <= !owner_d;
            d_rvalid_q <= owner_d;
            state      <= RESP;
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt    <= '0;
            i_rvalid_q <= !owner_d;
            d_rvalid_q <= owner_d;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory fields are visible only during the single ISSUE cycle.
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_en_q && we_q;
  assign mem_wstrb = mem_en_q ? wstrb_q : 4'h0;
  assign mem_addr  = mem_en_q ? addr_q  : 32'h0;
  assign mem_wdata = mem_en_q ? wdata_q : 32'h0;

  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rvalid_q ? mem_rdata : 32'h0;
  assign d_rdata  = d_rvalid_q ? mem_rdata : 32'h0;
  assign busy     = (state != IDLE);

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_stall_cnt <= '0;
      d_stall_cnt <= '0;
    end else begin
      if (i_req && !i_ready && i_stall_cnt != 32'hFFFF_FFFF)
        i_stall_cnt <= i_stall_cnt + 32'd1;
      if (d_req && !d_ready && d_stall_cnt != 32'hFFFF_FFFF)
        d_stall_cnt <= d_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// starvation and mid-transaction reset sequences against a latency-accurate memory model.
module tb_mem_port_arbiter;

  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_stall_cnt;
  logic [31:0] d_stall_cnt;
`endif

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_PERF_CNT_EN
    , .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data is valid only in the cycle MEM_LAT after mem_en.
  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] rd_data;
  int          rd_cnt;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    if (a == 32'h40) return 32'h0050_0093;
    return a ^ 32'hA5A5_0000;
  endfunction

  initial rd_cnt = 0;
  always @(posedge clk) begin
    if (mem_en) begin
      rd_cnt  <= MEM_LAT;
      rd_data <= mem_read(mem_addr);
      if (mem_we) begin
        logic [31:0] w;
        w = mem_read(mem_addr);
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
        mem_store[mem_addr] = w;
      end
    end else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
    end
  end
  assign mem_rdata = (rd_cnt == 1) ? rd_data : 32'hBAD0_BAD0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".ctrl"}, {21'b0, i_ready, i_rvalid, d_ready, d_rvalid, mem_en, mem_we,
                           mem_wstrb, busy}, 32'h0);
    check({tag, ".i_rdata"}, i_rdata, 32'h0);
    check({tag, ".d_rdata"}, d_rdata, 32'h0);
    check({tag, ".mem_addr"}, mem_addr, 32'h0);
    check({tag, ".mem_wdata"}, mem_wdata, 32'h0);
  endtask

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_i_ready;
    logic        e_d_ready;
    logic        e_i_rvalid;
    logic [31:0] e_i_rdata;
    logic        e_d_rvalid;
    logic [31:0] e_d_rdata;
    logic        d_rdata_dc;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [3:0]  e_mem_wstrb;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_busy;
  } vec_t;

  vec_t vecs [19];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    logic [4:0] rv;
    int         ng;
    int         both;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] i_base;
    logic [31:0] d_base;
`endif

    // Fetch from 0x40.
    vecs[0]  = '{1, 'h40, 0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0,      1, 0, 0, 'h40, 0, 1};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 1};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 1, 'h0050_0093, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0};
    // Full-word store to 0x100.
    vecs[5]  = '{0, 0, 1, 1, 'hF, 'h100, 'hDEAD_BEEF, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0,      1, 1, 'hF, 'h100, 'hDEAD_BEEF, 1};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 1, 0, 1,      0, 0, 0, 0, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0};
    // Simultaneous requests: D load of 0x100 first, then I fetch of 0x40.
    vecs[10] = '{1, 'h40, 1, 0, 0, 'h100, 0,  0, 1, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 'h40, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0,      1, 0, 0, 'h100, 0, 1};
    vecs[12] = '{1, 'h40, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 1};
    vecs[13] = '{1, 'h40, 0, 0, 0, 0, 0,      0, 0, 0, 0, 1, 'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 1};
    vecs[14] = '{1, 'h40, 0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0,      1, 0, 0, 'h40, 0, 1};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 1};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 1, 'h0050_0093, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[18] = '{0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0};

    reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_wstrb = '0; d_addr = '0; d_wdata = '0;
    #1 check_quiet("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      i_req = vecs[i].i_req;  i_addr = vecs[i].i_addr;
      d_req = vecs[i].d_req;  d_we = vecs[i].d_we;   d_wstrb = vecs[i].d_wstrb;
      d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      @(negedge clk);
      check($sformatf("r%0d.i_ready", i),   i_ready,   vecs[i].e_i_ready);
      check($sformatf("r%0d.d_ready", i),   d_ready,   vecs[i].e_d_ready);
      check($sformatf("r%0d.i_rvalid", i),  i_rvalid,  vecs[i].e_i_rvalid);
      check($sformatf("r%0d.i_rdata", i),   i_rdata,   vecs[i].e_i_rdata);
      check($sformatf("r%0d.d_rvalid", i),  d_rvalid,  vecs[i].e_d_rvalid);
      if (!vecs[i].d_rdata_dc)
        check($sformatf("r%0d.d_rdata", i), d_rdata,   vecs[i].e_d_rdata);
      check($sformatf("r%0d.mem_en", i),    mem_en,    vecs[i].e_mem_en);
      check($sformatf("r%0d.mem_we", i),    mem_we,    vecs[i].e_mem_we);
      check($sformatf("r%0d.mem_wstrb", i), mem_wstrb, vecs[i].e_mem_wstrb);
      check($sformatf("r%0d.mem_addr", i),  mem_addr,  vecs[i].e_mem_addr);
      check($sformatf("r%0d.mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
      check($sformatf("r%0d.busy", i),      busy,      vecs[i].e_busy);
`ifdef ARB_PERF_CNT_EN
      if (i == 9) begin
        i_base = i_stall_cnt;
        d_base = d_stall_cnt;
      end
      if (i == 18) begin
        check("perf.i_stall", i_stall_cnt - i_base, 32'd4);
        check("perf.d_stall", d_stall_cnt - d_base, 32'd0);
      end
`endif
    end

    // Starvation: both requesters held high; I must win the fifth grant.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    ng = 0; pat = '0; both = 0;
    for (int c = 0; c < 100 && ng < 6; c++) begin
      @(negedge clk);
      if (i_ready && d_ready) both++;
      if (i_ready || d_ready) begin
        pat[ng] = i_ready;
        ng++;
      end
      @(posedge clk); #1;
    end
    i_req = 1'b0; d_req = 1'b0;
    check("starve.grants", ng, 6);
    check("starve.order", {26'b0, pat}, 32'b010000);
    check("starve.both_ready", both, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("starve.drain", busy, 0);

    // Reset asserted while a fetch is in WAIT.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h40;
    @(negedge clk) check("rst.accept", i_ready, 1);
    @(posedge clk); #1 i_req = 1'b0;
    @(negedge clk) check("rst.issue", mem_en, 1);
    @(posedge clk); #1;
    check("rst.in_wait", busy, 1);
    #2 reset = 1'b0; i_req = 1'b1;
    #1 check_quiet("rst.async");
    repeat (3) begin
      @(negedge clk) check_quiet("rst.hold");
    end
    #1 reset = 1'b1;
    #1 check("rst.first_ready", i_ready, 1);
    @(posedge clk); #1 i_req = 1'b0;
    rv = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rv[k] = i_rvalid;
      if (k == 2) check("rst.new_rdata", i_rdata, 32'h0050_0093);
    end
    check("rst.rvalid_timing", {27'b0, rv}, 32'b00100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
